// File: rtl/prv_trap_sequencer.sv
// prv_trap_sequencer
// Arbitrates exceptions, mret and interrupts by fixed RISC-V priority.
// Holds a flush request (intr) until the pipeline drains, then issues a
// one-cycle PC redirect along with the CSR commit strobes.
//
// Ports:
//   CLK, RST                    clock, synchronous active-high reset
//   exc_req, epc, badaddr       exception requests (bit = code) and trap data
//   mret, mepc_r                return request and the current mepc
//   irq_pending, irq_enable,
//   mie_global                  mip, mie, mstatus.MIE
//   mtvec                       trap vector CSR, sampled in the redirect cycle
//   pipe_clear                  pipeline drained
//   intr, busy                  flush request, sequencer not idle
//   insert_pc, priv_pc          redirect strobe and target
//   trap_commit, mepc_o,
//   mcause_o, mtval_o           trap CSR write strobe and data
//   mret_commit                 privilege stack pop
//
// state     | meaning
// ----------+-----------------------------------------------------------
// IDLE      | accepting requests
// TRAP_WAIT | trap accepted, flushing until pipe_clear
// RET_WAIT  | mret accepted, flushing until pipe_clear
// INSERT    | one-cycle redirect plus commit strobe
module prv_trap_sequencer #(
  parameter int XLEN        = 32,
  parameter int NUM_IRQ     = 32,
  parameter bit VECTORED_EN = 1'b1
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic [15:0]        exc_req,
  input  logic [XLEN-1:0]    epc,
  input  logic [XLEN-1:0]    badaddr,
  input  logic               mret,
  input  logic [NUM_IRQ-1:0] irq_pending,
  input  logic [NUM_IRQ-1:0] irq_enable,
  input  logic               mie_global,
  input  logic [XLEN-1:0]    mtvec,
  input  logic [XLEN-1:0]    mepc_r,
  input  logic               pipe_clear,
  output logic               intr,
  output logic               insert_pc,
  output logic [XLEN-1:0]    priv_pc,
  output logic               trap_commit,
  output logic [XLEN-1:0]    mepc_o,
  output logic [XLEN-1:0]    mcause_o,
  output logic [XLEN-1:0]    mtval_o,
  output logic               mret_commit,
  output logic               busy
);

  typedef enum logic [1:0] {IDLE, TRAP_WAIT, RET_WAIT, INSERT} state_e;

  // Codes 10 and 14 are reserved and never trap.
  localparam logic [15:0] EXC_MASK = 16'hBBFF;
  localparam int          NUM_EXC  = 14;
  // Highest priority first.
  localparam logic [3:0]  EXC_PRIO [NUM_EXC] = '{4'd3, 4'd12, 4'd1, 4'd2, 4'd0, 4'd8, 4'd9,
                                                 4'd11, 4'd6, 4'd4, 4'd15, 4'd13, 4'd7, 4'd5};

  state_e            state_q, state_d;
  logic [XLEN-1:0]   mepc_q, mepc_d;
  logic [XLEN-1:0]   mcause_q, mcause_d;
  logic [XLEN-1:0]   mtval_q, mtval_d;
  logic [XLEN-1:0]   ret_pc_q, ret_pc_d;
  logic              is_ret_q, is_ret_d;

  logic [15:0]       exc_valid;
  logic [3:0]        exc_code;
  logic [NUM_IRQ-1:0] irq_act;
  logic              irq_hit;
  logic [XLEN-1:0]   irq_code;
  logic [XLEN-1:0]   base;
  logic [XLEN-1:0]   vec_off;

  // Priority encoders: scan lowest priority first so the highest hit wins.
  always_comb begin
    exc_valid = exc_req & EXC_MASK;
    exc_code  = 4'd0;
    for (int i = NUM_EXC - 1; i >= 0; i--) begin
      if (exc_valid[EXC_PRIO[i]]) exc_code = EXC_PRIO[i];
    end

    irq_act  = irq_pending & irq_enable;
    irq_hit  = 1'b0;
    irq_code = '0;
    for (int i = NUM_IRQ - 1; i >= 16; i--) begin
      if (irq_act[i]) begin
        irq_hit  = 1'b1;
        irq_code = XLEN'(i);
      end
    end
    if (irq_act[7])  begin irq_hit = 1'b1; irq_code = XLEN'(7);  end
    if (irq_act[3])  begin irq_hit = 1'b1; irq_code = XLEN'(3);  end
    if (irq_act[11]) begin irq_hit = 1'b1; irq_code = XLEN'(11); end
  end

  always_comb begin
    state_d  = state_q;
    mepc_d   = mepc_q;
    mcause_d = mcause_q;
    mtval_d  = mtval_q;
    ret_pc_d = ret_pc_q;
    is_ret_d = is_ret_q;
    case (state_q)
      IDLE: begin
        if (|exc_valid) begin
          state_d  = TRAP_WAIT;
          is_ret_d = 1'b0;
          mepc_d   = epc;
          mcause_d = XLEN'(exc_code);
          case (exc_code)
            4'd3:               mtval_d = epc;
            4'd8, 4'd9, 4'd11:  mtval_d = '0;
            default:            mtval_d = badaddr;
          endcase
        end else if (mret) begin
          state_d  = RET_WAIT;
          is_ret_d = 1'b1;
          ret_pc_d = {mepc_r[XLEN-1:2], 2'b00};
        end else if (mie_global && irq_hit) begin
          state_d  = TRAP_WAIT;
          is_ret_d = 1'b0;
          mepc_d   = epc;
          mcause_d = {1'b1, irq_code[XLEN-2:0]};
          mtval_d  = '0;
        end
      end
      TRAP_WAIT, RET_WAIT: begin
        if (pipe_clear) state_d = INSERT;
      end
      INSERT:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= IDLE;
      mepc_q   <= '0;
      mcause_q <= '0;
      mtval_q  <= '0;
      ret_pc_q <= '0;
      is_ret_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      mepc_q   <= mepc_d;
      mcause_q <= mcause_d;
      mtval_q  <= mtval_d;
      ret_pc_q <= ret_pc_d;
      is_ret_q <= is_ret_d;
    end
  end

  // The vector offset reuses the latched cause code; the flag bit sits
  // above the slice so it never leaks into the offset.
  always_comb begin
    base    = {mtvec[XLEN-1:2], 2'b00};
    vec_off = {mcause_q[XLEN-3:0], 2'b00};
    priv_pc = '0;
    if (state_q == INSERT) begin
      if (is_ret_q)
        priv_pc = ret_pc_q;
      else if (VECTORED_EN && mtvec[1:0] == 2'b01 && mcause_q[XLEN-1])
        priv_pc = base + vec_off;
      else
        priv_pc = base;
    end
  end

  assign intr        = (state_q == TRAP_WAIT) || (state_q == RET_WAIT);
  assign busy        = (state_q != IDLE);
  assign insert_pc   = (state_q == INSERT);
  assign trap_commit = (state_q == INSERT) && !is_ret_q;
  assign mret_commit = (state_q == INSERT) && is_ret_q;
  assign mepc_o      = mepc_q;
  assign mcause_o    = mcause_q;
  assign mtval_o     = mtval_q;

endmodule

// File: tb/tb_prv_trap_sequencer.sv
module tb_prv_trap_sequencer;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic [15:0] exc_req = '0;
  logic [31:0] epc = '0, badaddr = '0, mtvec = '0, mepc_r = '0;
  logic        mret = 1'b0, mie_global = 1'b0, pipe_clear = 1'b0;
  logic [31:0] irq_pending = '0, irq_enable = '0;

  logic        intr, insert_pc, trap_commit, mret_commit, busy;
  logic [31:0] priv_pc, mepc_o, mcause_o, mtval_o;
  logic        d_intr, d_insert_pc, d_trap_commit, d_mret_commit, d_busy;
  logic [31:0] d_priv_pc, d_mepc_o, d_mcause_o, d_mtval_o;

  always #5 CLK = ~CLK;

  prv_trap_sequencer #(.XLEN(32), .NUM_IRQ(32), .VECTORED_EN(1'b1)) dut (
    .CLK(CLK), .RST(RST), .exc_req(exc_req), .epc(epc), .badaddr(badaddr), .mret(mret),
    .irq_pending(irq_pending), .irq_enable(irq_enable), .mie_global(mie_global),
    .mtvec(mtvec), .mepc_r(mepc_r), .pipe_clear(pipe_clear), .intr(intr),
    .insert_pc(insert_pc), .priv_pc(priv_pc), .trap_commit(trap_commit), .mepc_o(mepc_o),
    .mcause_o(mcause_o), .mtval_o(mtval_o), .mret_commit(mret_commit), .busy(busy));

  // Same stimulus, direct-only build.
  prv_trap_sequencer #(.XLEN(32), .NUM_IRQ(32), .VECTORED_EN(1'b0)) dut_d (
    .CLK(CLK), .RST(RST), .exc_req(exc_req), .epc(epc), .badaddr(badaddr), .mret(mret),
    .irq_pending(irq_pending), .irq_enable(irq_enable), .mie_global(mie_global),
    .mtvec(mtvec), .mepc_r(mepc_r), .pipe_clear(pipe_clear), .intr(d_intr),
    .insert_pc(d_insert_pc), .priv_pc(d_priv_pc), .trap_commit(d_trap_commit),
    .mepc_o(d_mepc_o), .mcause_o(d_mcause_o), .mtval_o(d_mtval_o),
    .mret_commit(d_mret_commit), .busy(d_busy));

  typedef struct {
    bit          taken;
    bit          is_ret;
    logic [31:0] mcause;
    logic [31:0] mepc;
    logic [31:0] mtval;
    logic [31:0] pc_vec;
    logic [31:0] pc_dir;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   failures = 0;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h expected=0x%08h at %0t", name, act, exp, $time);
    end
  endfunction

  // Reference model: walks the architectural priority lists directly.
  function automatic exp_t model(logic [15:0] exc, logic m, logic [31:0] pend, logic [31:0] en,
                                 logic gie, logic [31:0] e, logic [31:0] b, logic [31:0] tv,
                                 logic [31:0] mr);
    exp_t r;
    int   exc_order[14] = '{3, 12, 1, 2, 0, 8, 9, 11, 6, 4, 15, 13, 7, 5};
    int   irq_order[$];
    logic [31:0] act;
    int   code;
    bit   is_irq;
    r = '{taken: 0, is_ret: 0, mcause: 0, mepc: 0, mtval: 0, pc_vec: 0, pc_dir: 0};
    code = -1;
    is_irq = 0;
    foreach (exc_order[k]) begin
      if (code < 0 && exc[exc_order[k]]) code = exc_order[k];
    end
    if (code >= 0) begin
      r.taken  = 1;
      r.mcause = code;
      r.mepc   = e;
      if (code == 3) r.mtval = e;
      else if (code inside {8, 9, 11}) r.mtval = 0;
      else r.mtval = b;
    end else if (m) begin
      r.taken  = 1;
      r.is_ret = 1;
      r.pc_vec = mr & ~32'd3;
      r.pc_dir = mr & ~32'd3;
      return r;
    end else if (gie) begin
      act = pend & en;
      irq_order = '{11, 3, 7};
      for (int k = 16; k < 32; k++) irq_order.push_back(k);
      foreach (irq_order[k]) begin
        if (code < 0 && act[irq_order[k]]) code = irq_order[k];
      end
      if (code >= 0) begin
        r.taken  = 1;
        is_irq   = 1;
        r.mcause = 32'h8000_0000 + code;
        r.mepc   = e;
        r.mtval  = 0;
      end
    end
    if (!r.taken) return r;
    r.pc_dir = tv & ~32'd3;
    r.pc_vec = (is_irq && tv[1:0] == 2'b01) ? r.pc_dir + 4 * code : r.pc_dir;
    return r;
  endfunction

  // Monitor: every redirect must match the oldest outstanding expectation.
  always @(negedge CLK) begin
    if (insert_pc === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_insert priv_pc=0x%08h at %0t", priv_pc, $time);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("trap_commit", {31'd0, trap_commit}, {31'd0, !e.is_ret});
        chk("mret_commit", {31'd0, mret_commit}, {31'd0, e.is_ret});
        chk("priv_pc_vec", priv_pc, e.pc_vec);
        chk("priv_pc_dir", d_priv_pc, e.pc_dir);
        chk("d_insert_pc", {31'd0, d_insert_pc}, 32'd1);
        if (!e.is_ret) begin
          chk("mcause_o", mcause_o, e.mcause);
          chk("mepc_o", mepc_o, e.mepc);
          chk("mtval_o", mtval_o, e.mtval);
        end
      end
    end
  end

  task automatic set_req(logic [15:0] exc, logic m, logic [31:0] pend, logic [31:0] en,
                         logic gie, logic [31:0] e, logic [31:0] b, logic [31:0] tv,
                         logic [31:0] mr);
    exc_req = exc; mret = m; irq_pending = pend; irq_enable = en;
    mie_global = gie; epc = e; badaddr = b; mtvec = tv; mepc_r = mr;
  endtask

  // One request presented for a single IDLE cycle, then pipe_clear pulsed
  // 'delay' cycles after the first wait cycle.
  task automatic txn(logic [15:0] exc, logic m, logic [31:0] pend, logic [31:0] en,
                     logic gie, logic [31:0] e, logic [31:0] b, logic [31:0] tv,
                     logic [31:0] mr, int delay);
    exp_t x;
    logic [31:0] t;
    x = model(exc, m, pend, en, gie, e, b, tv, mr);
    t = {31'd0, x.taken};
    if (x.taken) exp_q.push_back(x);
    @(posedge CLK); #1;
    set_req(exc, m, pend, en, gie, e, b, tv, mr);
    @(posedge CLK); #1;
    exc_req = '0; mret = 1'b0; irq_pending = '0;
    pipe_clear = (delay == 0);
    for (int k = 1; k <= delay; k++) begin
      @(negedge CLK);
      chk("intr_wait", {31'd0, intr}, t);
      @(posedge CLK); #1;
      pipe_clear = (k == delay);
    end
    @(negedge CLK);
    chk("intr_busy_n1", {30'd0, intr, busy}, {30'd0, x.taken, x.taken});
    @(posedge CLK); #1;
    pipe_clear = 1'b0;
    @(negedge CLK);
    chk("insert_timing", {31'd0, insert_pc}, t);
    @(posedge CLK);
    @(negedge CLK);
    chk("idle_after", {30'd0, intr, busy}, 32'd0);
  endtask

  initial begin
    exp_t x;
    // Reset state
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    chk("rst_strobes", {27'd0, intr, insert_pc, trap_commit, mret_commit, busy}, 32'd0);
    chk("rst_mcause", mcause_o, 32'd0);
    chk("rst_mepc", mepc_o, 32'd0);
    chk("rst_mtval", mtval_o, 32'd0);
    chk("rst_priv_pc", priv_pc, 32'd0);
    @(posedge CLK); #1 RST = 1'b0;

    // Load fault
    txn(16'h0020, 0, 0, 0, 0, 32'h100, 32'h8000_1003, 32'h200, 0, 3);
    // Simultaneous exceptions
    txn(16'h000D, 0, 0, 0, 0, 32'h40, 32'h1234, 32'h300, 0, 1);
    txn(16'h2010, 0, 0, 0, 0, 32'h44, 32'h5678, 32'h300, 0, 0);
    // Reserved codes only, with an interrupt behind them
    txn(16'h4400, 0, 32'h8, 32'h8, 1, 32'h48, 32'h9, 32'h301, 0, 0);
    // Vectored interrupts (direct build checked in parallel)
    txn(0, 0, 32'h888, 32'h888, 1, 32'h50, 32'h77, 32'h1001, 0, 2);
    txn(0, 0, 32'h0012_0000, 32'hFFFF_FFFF, 1, 32'h54, 0, 32'h1001, 0, 0);
    txn(0, 0, 32'h0000_0080, 32'h0000_0080, 1, 32'h58, 0, 32'h1003, 0, 0);
    // Arbitration
    txn(16'h0100, 1, 32'h800, 32'h800, 1, 32'h60, 32'h1, 32'h400, 32'h999, 1);
    txn(0, 1, 32'h800, 32'h800, 1, 32'h64, 0, 32'h401, 32'h0000_ABCF, 1);
    txn(0, 0, 32'h888, 32'h888, 0, 32'h68, 0, 32'h401, 0, 1);
    txn(16'h0800, 0, 0, 0, 0, 32'h6C, 32'hDEAD, 32'h500, 0, 0);

    // Mid-wait request ignored
    x = model(16'h0004, 0, 0, 0, 0, 32'h70, 32'hBEEF, 32'h600, 0);
    exp_q.push_back(x);
    @(posedge CLK); #1 set_req(16'h0004, 0, 0, 0, 0, 32'h70, 32'hBEEF, 32'h600, 0);
    @(posedge CLK); #1 exc_req = 16'h0008; epc = 32'h74;
    repeat (2) @(posedge CLK);
    #1 exc_req = '0; pipe_clear = 1'b1;
    @(posedge CLK); #1 pipe_clear = 1'b0;
    repeat (4) @(posedge CLK);
    @(negedge CLK);
    chk("midwait_queue", exp_q.size(), 32'd0);
    chk("midwait_idle", {31'd0, busy}, 32'd0);

    // Reset during TRAP_WAIT
    @(posedge CLK); #1 set_req(16'h0002, 0, 0, 0, 0, 32'h80, 32'h81, 32'h700, 0);
    @(posedge CLK); #1 exc_req = '0;
    @(negedge CLK);
    chk("pre_rst_intr", {31'd0, intr}, 32'd1);
    @(posedge CLK); #1 RST = 1'b1;
    @(posedge CLK);
    @(negedge CLK);
    chk("abort_strobes", {27'd0, intr, insert_pc, trap_commit, mret_commit, busy}, 32'd0);
    chk("abort_csr", mcause_o | mepc_o | mtval_o | priv_pc, 32'd0);
    @(posedge CLK); #1 RST = 1'b0; pipe_clear = 1'b1;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    chk("abort_no_insert", {31'd0, insert_pc}, 32'd0);
    @(posedge CLK); #1 pipe_clear = 1'b0;

    // Throughput: pipe_clear tied high, request held
    x = model(16'h0040, 0, 0, 0, 0, 32'h90, 32'h91, 32'h800, 0);
    exp_q.push_back(x);
    exp_q.push_back(x);
    @(posedge CLK); #1 set_req(16'h0040, 0, 0, 0, 0, 32'h90, 32'h91, 32'h800, 0);
    pipe_clear = 1'b1;
    @(posedge CLK); @(negedge CLK);
    chk("tp_intr_n1", {31'd0, intr}, 32'd1);
    @(posedge CLK); @(negedge CLK);
    chk("tp_insert_n2", {31'd0, insert_pc}, 32'd1);
    @(posedge CLK); @(negedge CLK);
    chk("tp_idle_n3", {31'd0, busy}, 32'd0);
    @(posedge CLK); #1 exc_req = '0;
    @(negedge CLK);
    chk("tp_intr_n4", {31'd0, intr}, 32'd1);
    @(posedge CLK); @(negedge CLK);
    chk("tp_insert_n5", {31'd0, insert_pc}, 32'd1);
    @(posedge CLK); #1 pipe_clear = 1'b0;
    @(negedge CLK);
    chk("tp_queue", exp_q.size(), 32'd0);

    // Randomized traffic
    for (int n = 0; n < 60; n++) begin
      logic [15:0] ex;
      logic [31:0] pe, en;
      ex = ($urandom_range(0, 1) == 0) ? 16'd0 : 16'($urandom) & 16'($urandom);
      pe = $urandom;
      en = $urandom;
      if ($urandom_range(0, 1) == 1) pe = pe & 32'hFFFF_0000;
      txn(ex, 1'($urandom_range(0, 3) == 0), pe, en, 1'($urandom),
          $urandom, $urandom, $urandom, $urandom, $urandom_range(0, 3));
    end

    repeat (3) @(posedge CLK);
    @(negedge CLK);
    chk("final_queue", exp_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
